// File: rtl/shift_chain_rx.sv
// Serial tail receiver: deserializes the shift chain into WIDTH-bit words and queues them.
// Latency: out_valid rises 1 cycle after the completing bit when the FIFO was empty.
// Backpressure: a full FIFO parks the finished word in STALL; sbusy=1 and offered bits are dropped.
//
// Ports:
//   pclk, prst_n          clock (rising edge), asynchronous active-low reset
//   sin, sen, sdir, sclr  serial bit, shift enable, bit order (1 = MSB-first), word clear
//   sbusy, cnt, ovf       chain backpressure, bits in the current word, sticky drop flag
//   out_valid/out_ready   head-of-FIFO handshake; out_data / out_perr are the head word
// Optional feature: define SHIFT_CHAIN_RX_PARITY_EN to append an odd-parity bit to each word.

// Small generic FIFO. Push while full is accepted only together with a pop
// of a non-empty FIFO; pop while empty is ignored. Entries reset to zero so
// the head output is zero out of reset.
module shift_chain_rx_fifo #(
  parameter int W     = 17,
  parameter int DEPTH = 2
) (
  input  logic         pclk,
  input  logic         prst_n,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head_dat
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

module shift_chain_rx #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic                       pclk,
  input  logic                       prst_n,
  input  logic                       sin,
  input  logic                       sen,
  input  logic                       sdir,
  input  logic                       sclr,
  output logic                       sbusy,
  output logic [$clog2(WIDTH+2)-1:0] cnt,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_perr,
  output logic                       ovf
);
`ifdef SHIFT_CHAIN_RX_PARITY_EN
  localparam int N  = WIDTH + 1;  // data bits followed by one parity bit
  localparam int FW = WIDTH + 1;  // FIFO entry {perr, data}
`else
  localparam int N  = WIDTH;
  localparam int FW = WIDTH;
`endif
  localparam int CW = $clog2(WIDTH + 2);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    STALL   = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_nxt;
  logic             dir_q;
  logic             word_dir;
  logic             accept;
  logic             data_bit;
  logic             complete;
  logic             pop;
  logic             stall_rel;
  logic             push;
  logic [FW-1:0]    push_dat;
  logic [FW-1:0]    fifo_head;
  logic             fifo_full;
  logic             fifo_empty;

`ifdef SHIFT_CHAIN_RX_PARITY_EN
  logic par_q;      // running XOR of the data bits of the current word
  logic perr_q;     // parity result of the word held in STALL
  logic word_perr;
`endif

  // The first bit of a word uses the live sdir; later bits use the latched one
  // so a mid-word sdir change cannot scramble the word.
  assign word_dir  = (state == IDLE) ? sdir : dir_q;
  assign shreg_nxt = word_dir ? {shreg[WIDTH-2:0], sin} : {sin, shreg[WIDTH-1:1]};
  assign accept    = sen & ~sclr & (state != STALL);
  assign complete  = accept & (cnt == CW'(N - 1));
  assign pop       = out_ready & ~fifo_empty;
  // The held word enters the FIFO in the same cycle the head leaves it.
  assign stall_rel = (state == STALL) & pop & ~sclr;
  assign push      = (complete & ~fifo_full) | stall_rel;

`ifdef SHIFT_CHAIN_RX_PARITY_EN
  // The parity bit is never shifted in, so shreg already holds the data
  // when the completing (parity) bit arrives.
  assign data_bit  = (cnt < CW'(WIDTH));
  assign word_perr = ~(par_q ^ sin);
  assign push_dat  = {(stall_rel ? perr_q : word_perr), shreg};
  assign out_perr  = fifo_head[WIDTH];
`else
  assign data_bit  = 1'b1;
  assign push_dat  = stall_rel ? shreg : shreg_nxt;
  assign out_perr  = 1'b0;
`endif

  assign out_data  = fifo_head[WIDTH-1:0];
  assign out_valid = ~fifo_empty;

  shift_chain_rx_fifo #(
    .W     (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .pclk     (pclk),
    .prst_n   (prst_n),
    .push     (push),
    .push_dat (push_dat),
    .pop      (pop),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head_dat (fifo_head)
  );

  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      state  <= IDLE;
      shreg  <= '0;
      dir_q  <= 1'b0;
      cnt    <= '0;
      sbusy  <= 1'b0;
      ovf    <= 1'b0;
`ifdef SHIFT_CHAIN_RX_PARITY_EN
      par_q  <= 1'b0;
      perr_q <= 1'b0;
`endif
    end else begin
      // Any bit offered while a finished word is parked is lost.
      if (sen && !sclr && state == STALL) begin
        ovf <= 1'b1;
      end

      if (sclr) begin
        state  <= IDLE;
        shreg  <= '0;
        dir_q  <= 1'b0;
        cnt    <= '0;
        sbusy  <= 1'b0;
`ifdef SHIFT_CHAIN_RX_PARITY_EN
        par_q  <= 1'b0;
`endif
      end else begin
        case (state)
          IDLE: begin
            if (accept) begin
              dir_q <= sdir;
              shreg <= shreg_nxt;
              cnt   <= CW'(1);
              state <= COLLECT;
`ifdef SHIFT_CHAIN_RX_PARITY_EN
              par_q <= sin;
`endif
            end
          end

          COLLECT: begin
            if (accept) begin
              if (data_bit) begin
                shreg <= shreg_nxt;
              end
`ifdef SHIFT_CHAIN_RX_PARITY_EN
              par_q <= par_q ^ sin;
`endif
              if (complete) begin
                if (!fifo_full) begin
                  cnt   <= '0;
                  shreg <= '0;
                  state <= IDLE;
                end else begin
                  // Park the word; cnt shows N so the chain sees a full word.
                  cnt   <= cnt + CW'(1);
                  sbusy <= 1'b1;
                  state <= STALL;
`ifdef SHIFT_CHAIN_RX_PARITY_EN
                  perr_q <= word_perr;
`endif
                end
              end else begin
                cnt <= cnt + CW'(1);
              end
            end
          end

          STALL: begin
            if (pop) begin
              cnt   <= '0;
              shreg <= '0;
              sbusy <= 1'b0;
              state <= IDLE;
            end
          end

          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end
endmodule

// File: doc/shift_chain_rx.md
# shift_chain_rx

Serial receiver at the tail of the bidirectional shift chain. It deserializes bits leaving the chain into WIDTH-bit words in either bit order, matching the chain's direction select. Completed words are queued in a small FIFO and presented on a valid/ready port. When the FIFO is full, the block back-pressures the chain with a busy flag.

## Interface
- WIDTH, 16, data bits per word (≥2)
- DEPTH, 2, output FIFO entries (power of two, ≥2)
- pclk  in  1  clock, rising edge
- prst_n  in  1  reset, asynchronous and active-low
- sin  in  1  serial data bit
- sen  in  1  shift enable; one bit is offered per cycle with sen=1
- sdir  in  1  bit order; 1 = MSB-first, 0 = LSB-first
- sclr  in  1  synchronous clear of the word being assembled; mirrors the chain clear
- sbusy  out  1  registered; 1 = offered bits are dropped
- cnt  out  $clog2(WIDTH+2)  bits accepted in the current word
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  consumer accepts the head word
- out_data  out  WIDTH  head word
- out_perr  out  1  parity error of the head word
- ovf  out  1  sticky; a bit was dropped

## Operation
- **States**
  - IDLE: no bits accepted yet.
  - COLLECT: word partially assembled.
  - STALL: word complete, FIFO full.
- **Word length** N = WIDTH, or WIDTH+1 when parity is compiled in.
- **IDLE**
  - With sen=1: accept the bit, latch sdir into the word's direction register, set cnt=1, go to COLLECT.
  - If N is 1, it cannot occur, because WIDTH ≥ 2.
- **COLLECT**
  - With sen=1: accept the bit and increment cnt.
  - The bit that makes cnt reach N completes the word.
    - FIFO not full: push, cnt→0, go to IDLE.
    - FIFO full: go to STALL. Hold the word and keep cnt at N.
  - The latched direction applies to the whole word. sdir changes mid-word are ignored.
- **Shift rules** (data bits only)
  - MSB-first: shreg ← {shreg[WIDTH-2:0], sin}.
  - LSB-first: shreg ← {sin, shreg[WIDTH-1:1]}.
  - The parity bit, if present, is the last bit and is not shifted into shreg.
- **STALL**
  - A cycle with a FIFO pop (out_valid & out_ready) pushes the held word in the same cycle, sets cnt→0 and goes to IDLE.
  - sen=1 in STALL: the bit is dropped and ovf is set. This includes the pop cycle.
- **sclr**
  - Dominates sen.
  - Clears shreg, cnt and the direction register, and forces IDLE, including from STALL, where the held word is discarded.
  - Does not touch the FIFO or ovf.
- **FIFO**
  - DEPTH entries of {perr, data}; out_data and out_perr are driven from the head entry.
  - Push and pop in the same cycle when full is legal only via the STALL release.
  - Pop when empty is ignored.
- **ovf** clears only on reset.

## Timing
- **Reset values**
  - State IDLE, shreg 0, cnt 0, FIFO empty.
  - out_valid 0, out_data 0, out_perr 0, sbusy 0, ovf 0.
- **Latency**
  - The completing bit is sampled at edge k.
  - out_valid is 1 after edge k if the FIFO was empty, so there is 1 cycle from the last sen cycle to out_valid.
  - out_data is stable while out_valid=1 and out_ready=0.
- **sbusy** is registered: it is 1 in the cycle after entry to STALL and 0 in the cycle after leaving it.
- **Async reset mid-word or in STALL:** all state returns to reset values immediately. No partial word is pushed.
- **Back-to-back words:** the completing bit of one word and the first bit of the next word may arrive on consecutive cycles, with no gap.

## Configuration
- **SHIFT_CHAIN_RX_PARITY_EN**
  - Defined:
    - N = WIDTH+1 and odd parity is checked.
    - perr = ~(XOR of all N bits).
    - perr is stored with the word and presented on out_perr.
  - Undefined:
    - N = WIDTH.
    - out_perr is tied 0 and no parity logic is present.

## Test plan
- **MSB-first word:** WIDTH=8, sdir=1, bits 1,1,0,0,0,0,0,1 on 8 consecutive sen cycles. Required: out_valid rises 1 cycle after the 8th bit with out_data=8'hC1, cnt=0.
- **LSB-first word and mid-word sdir toggle:** same bits with sdir=0, then toggle sdir after bit 3. Required: out_data=8'h83.
- **Full FIFO and STALL release:** out_ready=0 while 3 words are sent (DEPTH=2), with 2 extra sen bits during STALL. Required:
  - sbusy=1 and ovf=1.
  - On the first pop, the third word enters the FIFO and sbusy drops the next cycle.
  - The 2 extra bits are absent and all three words read back in order.
- **sclr mid-word:** 3 bits, then sclr together with sen=1. Required: cnt=0, no push, FIFO intact. A following 8-bit word is received intact.
- **Async reset while in STALL with a full FIFO:** assert prst_n=0. Required: all outputs go to 0 immediately, and the first word after release is correct.
- **Parity (SHIFT_CHAIN_RX_PARITY_EN defined):** data 8'hC1 MSB-first.
  - Parity bit 0 gives out_perr=0 (total ones 3, odd).
  - Parity bit 1 gives out_perr=1.
